// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer: FSM state encoding,
// BCD digit limits and a nibble clamp helper.
package timer_pkg;

  localparam int DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] BCD_MAX  = 4'd9;
  localparam logic [DIGIT_W-1:0] BCD_ZERO = 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Non-decimal nibbles (A..F) saturate to 9 so the counter never holds an illegal digit.
  function automatic logic [DIGIT_W-1:0] bcd_clamp(input logic [DIGIT_W-1:0] nibble);
    return (nibble > BCD_MAX) ? BCD_MAX : nibble;
  endfunction

endpackage

// File: rtl/bcd_digit_cell.sv
// One BCD digit of the countdown chain: loadable register that decrements on
// an incoming borrow and passes a borrow on when it wraps from 0 to 9.
module bcd_digit_cell
  import timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_nibble_i,
  input  logic               borrow_i,
  input  logic               en_i,
  output logic [DIGIT_W-1:0] digit_o,
  output logic               borrow_o,
  output logic               is_zero_o
);

  logic [DIGIT_W-1:0] digit_q;
  logic [DIGIT_W-1:0] digit_d;

  assign is_zero_o = (digit_q == BCD_ZERO);
  assign borrow_o  = borrow_i & is_zero_o;
  assign digit_o   = digit_q;

  always_comb begin
    digit_d = digit_q;
    if (load_i) begin
      digit_d = bcd_clamp(load_nibble_i);
    end else if (en_i && borrow_i) begin
      digit_d = is_zero_o ? BCD_MAX : (digit_q - 4'd1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      digit_q <= BCD_ZERO;
    end else begin
      digit_q <= digit_d;
    end
  end

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer with start/pause control, expiry level and done pulse.
// Optional low-time warn output is built only when TIMER_WARN_EN is defined.
module bcd_countdown_timer
  import timer_pkg::*;
#(
  parameter int                            NUM_DIGITS = 4,
  parameter logic [DIGIT_W*NUM_DIGITS-1:0] WARN_VAL   = 'h0005
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load_i,
  input  logic [DIGIT_W*NUM_DIGITS-1:0] load_val_i,
  input  logic                          start_i,
  input  logic                          pause_i,
  input  logic                          tick_i,
  output logic [DIGIT_W*NUM_DIGITS-1:0] digits_o,
  output logic                          running_o,
  output logic                          expired_o,
  output logic                          done_pulse_o,
  output logic                          warn_o
);

  localparam int W = DIGIT_W * NUM_DIGITS;

  state_t state_q, state_d;
  logic   done_q, done_d;

  logic [NUM_DIGITS:0]   borrowChain;
  logic [NUM_DIGITS-1:0] isZero;
  logic                  allZero;
  logic                  lastCount;
  logic                  underflow;
  logic                  countEn;

  assign borrowChain[0] = tick_i;
  assign allZero        = &isZero;
  assign lastCount      = (digits_o == W'(1));
  // A borrow out of the top digit means the count is already zero; block the wrap to all nines.
  assign underflow      = borrowChain[NUM_DIGITS];
  assign countEn        = (state_q == ST_RUN) && !load_i && !pause_i && !underflow;

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : gDigit
    bcd_digit_cell u_cell (
      .clk           (clk),
      .rst           (rst),
      .load_i        (load_i),
      .load_nibble_i (load_val_i[i*DIGIT_W +: DIGIT_W]),
      .borrow_i      (borrowChain[i]),
      .en_i          (countEn),
      .digit_o       (digits_o[i*DIGIT_W +: DIGIT_W]),
      .borrow_o      (borrowChain[i+1]),
      .is_zero_o     (isZero[i])
    );
  end

  always_comb begin
    state_d = state_q;
    if (load_i) begin
      state_d = ST_IDLE;
    end else if (pause_i) begin
      if (state_q == ST_RUN) state_d = ST_PAUSED;
    end else if (start_i) begin
      if ((state_q == ST_IDLE) || (state_q == ST_PAUSED)) begin
        state_d = allZero ? ST_EXPIRED : ST_RUN;
      end
    end else if (tick_i && (state_q == ST_RUN) && (lastCount || underflow)) begin
      state_d = ST_EXPIRED;
    end
    done_d = (state_d == ST_EXPIRED) && (state_q != ST_EXPIRED);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
    end
  end

  assign running_o    = (state_q == ST_RUN);
  assign expired_o    = (state_q == ST_EXPIRED);
  assign done_pulse_o = done_q;

`ifdef TIMER_WARN_EN
  // Packed BCD orders the same as its decimal value, so a plain unsigned compare is MSD-first.
  assign warn_o = ((state_q == ST_RUN) || (state_q == ST_PAUSED)) && !allZero &&
                  (digits_o <= WARN_VAL);
`else
  assign warn_o = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Scoreboard bench for bcd_countdown_timer: directed vectors push expected outputs,
// a monitor pops and compares one entry after every active edge that had stimulus.
module tb_bcd_countdown_timer;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] loadVal;
  logic        start;
  logic        pause;
  logic        tick;
  logic [15:0] digits;
  logic        running;
  logic        expired;
  logic        donePulse;
  logic        warn;

  typedef struct {
    logic [15:0] d;
    logic        run;
    logic        exp;
    logic        done;
    logic        warn;
    string       name;
  } exp_t;

  exp_t expQ[$];
  int   vectorsApplied = 0;
  int   miscompares    = 0;

  bcd_countdown_timer #(
    .NUM_DIGITS (4),
    .WARN_VAL   (16'h0005)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load_i       (load),
    .load_val_i   (loadVal),
    .start_i      (start),
    .pause_i      (pause),
    .tick_i       (tick),
    .digits_o     (digits),
    .running_o    (running),
    .expired_o    (expired),
    .done_pulse_o (donePulse),
    .warn_o       (warn)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input string name, input logic r, input logic l,
                               input logic [15:0] lv, input logic s, input logic p,
                               input logic t, input logic [15:0] expD, input logic expRun,
                               input logic expExp, input logic expDone, input logic expWarn);
    exp_t e;
    @(negedge clk);
    rst     = r;
    load    = l;
    loadVal = lv;
    start   = s;
    pause   = p;
    tick    = t;
    e.d    = expD;
    e.run  = expRun;
    e.exp  = expExp;
    e.done = expDone;
`ifdef TIMER_WARN_EN
    e.warn = expWarn;
`else
    e.warn = 1'b0;
`endif
    e.name = name;
    expQ.push_back(e);
  endtask

  task automatic checkOutput(input exp_t e);
    vectorsApplied++;
    if (digits !== e.d || running !== e.run || expired !== e.exp ||
        donePulse !== e.done || warn !== e.warn) begin
      miscompares++;
      $display("[TB] FAIL %s: got d=%h run=%b exp=%b done=%b warn=%b, want d=%h run=%b exp=%b done=%b warn=%b",
               e.name, digits, running, expired, donePulse, warn,
               e.d, e.run, e.exp, e.done, e.warn);
    end
  endtask

  // Monitor: outputs are sampled 1 time unit after each rising edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput(e);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b0; load = 1'b0; loadVal = 16'h0; start = 1'b0; pause = 1'b0; tick = 1'b0;

    //            name          rst load val      st pa tk  digits   run exp done warn
    applyStimulus("reset",       0, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    applyStimulus("load42",      1, 1, 16'h0042, 0, 0, 0, 16'h0042, 0, 0, 0, 0);
    applyStimulus("start42",     1, 0, 16'h0000, 1, 0, 0, 16'h0042, 1, 0, 0, 0);
    applyStimulus("tick41",      1, 0, 16'h0000, 0, 0, 1, 16'h0041, 1, 0, 0, 0);
    applyStimulus("rstMidRun",   0, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0, 0);
    applyStimulus("tickIdle",    1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 0, 0, 0);
    applyStimulus("load102Tick", 1, 1, 16'h0102, 0, 0, 1, 16'h0102, 0, 0, 0, 0);
    applyStimulus("startTick",   1, 0, 16'h0000, 1, 0, 1, 16'h0102, 1, 0, 0, 0);
    applyStimulus("tick101",     1, 0, 16'h0000, 0, 0, 1, 16'h0101, 1, 0, 0, 0);
    applyStimulus("tick100",     1, 0, 16'h0000, 0, 0, 1, 16'h0100, 1, 0, 0, 0);
    applyStimulus("ripple099",   1, 0, 16'h0000, 0, 0, 1, 16'h0099, 1, 0, 0, 0);
    applyStimulus("noTick",      1, 0, 16'h0000, 0, 0, 0, 16'h0099, 1, 0, 0, 0);

    applyStimulus("load2",       1, 1, 16'h0002, 0, 0, 0, 16'h0002, 0, 0, 0, 0);
    applyStimulus("start2",      1, 0, 16'h0000, 1, 0, 0, 16'h0002, 1, 0, 0, 1);
    applyStimulus("tick1",       1, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0, 1);
    applyStimulus("expire",      1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1, 0);
    applyStimulus("noWrap",      1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 0, 0);
    applyStimulus("startInExp",  1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 0, 0);

    applyStimulus("load10",      1, 1, 16'h0010, 0, 0, 0, 16'h0010, 0, 0, 0, 0);
    applyStimulus("start10",     1, 0, 16'h0000, 1, 0, 0, 16'h0010, 1, 0, 0, 0);
    applyStimulus("pauseTick",   1, 0, 16'h0000, 0, 1, 1, 16'h0010, 0, 0, 0, 0);
    applyStimulus("tickPaused",  1, 0, 16'h0000, 0, 0, 1, 16'h0010, 0, 0, 0, 0);
    applyStimulus("resume",      1, 0, 16'h0000, 1, 0, 0, 16'h0010, 1, 0, 0, 0);
    applyStimulus("tick09",      1, 0, 16'h0000, 0, 0, 1, 16'h0009, 1, 0, 0, 0);
    applyStimulus("startPause",  1, 0, 16'h0000, 1, 1, 0, 16'h0009, 0, 0, 0, 0);
    applyStimulus("resumeTick",  1, 0, 16'h0000, 1, 0, 1, 16'h0009, 1, 0, 0, 0);
    applyStimulus("tick08",      1, 0, 16'h0000, 0, 0, 1, 16'h0008, 1, 0, 0, 0);

    applyStimulus("clampA5",     1, 1, 16'h00A5, 0, 0, 0, 16'h0095, 0, 0, 0, 0);
    applyStimulus("clampFFFF",   1, 1, 16'hFFFF, 0, 0, 0, 16'h9999, 0, 0, 0, 0);
    applyStimulus("load0",       1, 1, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 0, 0);
    applyStimulus("startZero",   1, 0, 16'h0000, 1, 0, 0, 16'h0000, 0, 1, 1, 0);
    applyStimulus("doneOnce",    1, 0, 16'h0000, 0, 0, 0, 16'h0000, 0, 1, 0, 0);
    applyStimulus("load3FromEx", 1, 1, 16'h0003, 0, 0, 0, 16'h0003, 0, 0, 0, 0);
    applyStimulus("idlePauseSt", 1, 0, 16'h0000, 1, 1, 0, 16'h0003, 0, 0, 0, 0);

    applyStimulus("load7",       1, 1, 16'h0007, 0, 0, 0, 16'h0007, 0, 0, 0, 0);
    applyStimulus("start7",      1, 0, 16'h0000, 1, 0, 0, 16'h0007, 1, 0, 0, 0);
    applyStimulus("warn6",       1, 0, 16'h0000, 0, 0, 1, 16'h0006, 1, 0, 0, 0);
    applyStimulus("warn5",       1, 0, 16'h0000, 0, 0, 1, 16'h0005, 1, 0, 0, 1);
    applyStimulus("warn4",       1, 0, 16'h0000, 0, 0, 1, 16'h0004, 1, 0, 0, 1);
    applyStimulus("warnPaused",  1, 0, 16'h0000, 0, 1, 0, 16'h0004, 0, 0, 0, 1);
    applyStimulus("warnResume",  1, 0, 16'h0000, 1, 0, 0, 16'h0004, 1, 0, 0, 1);
    applyStimulus("warn3",       1, 0, 16'h0000, 0, 0, 1, 16'h0003, 1, 0, 0, 1);
    applyStimulus("warn2",       1, 0, 16'h0000, 0, 0, 1, 16'h0002, 1, 0, 0, 1);
    applyStimulus("warn1",       1, 0, 16'h0000, 0, 0, 1, 16'h0001, 1, 0, 0, 1);
    applyStimulus("warnExpire",  1, 0, 16'h0000, 0, 0, 1, 16'h0000, 0, 1, 1, 0);
    applyStimulus("load1",       1, 1, 16'h0001, 0, 0, 0, 16'h0001, 0, 0, 0, 0);

    @(negedge clk);
    load = 1'b0; start = 1'b0; pause = 1'b0; tick = 1'b0;
    repeat (2) @(negedge clk);

    vectorsApplied++;
    if (expQ.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL drain: got %0d pending entries, want 0", expQ.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
